fire_control_unit: RTL

- Downstream consumer of the target tracking unit.
- Takes its target_locked and distance_to_target outputs plus operator commands, and issues missile launch pulses when a locked target is in engagement range.
- Drives track_request back into the tracker's track_target_command input, to request a fresh radar pass while armed without lock.
- Fully clock-counted: no time-based delays, all outputs registered.

---
 rtl/fire_control_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fire_control_unit.sv
// fire_control_unit: takes the tracker's lock and distance plus operator
//    commands, and issues timed missile launch strobes.
// Latency: every output is registered. A fire command sampled at edge N
//    raises launch_missile at edge N, and it stays high FIRE_PULSE_CYCLES cycles.
// Backpressure: none. Commands are levels. Commands that do not apply to the
//    current state are ignored.
// Ports:
//    clk, rst (sync, active-high)
//    arm/disarm/fire/reload_command    operator levels
//    target_locked, distance_to_target from the tracker
//    track_request                     one-cycle pulse back to the tracker
//    launch_missile                    launch strobe
//    remaining_missiles                missiles left in the magazine
//    FCU_state                         state register
//    FCU_state encoding: 00 idle, 01 armed, 10 firing, 11 out of ammo
module fire_control_unit #(
   parameter int MAX_MISSILES      = 4,
   parameter int MIN_RANGE         = 300,
   parameter int MAX_RANGE         = 12000,
   parameter int FIRE_PULSE_CYCLES = 5,
   parameter int RETRACK_CYCLES    = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arm_command,
   input  logic        disarm_command,
   input  logic        fire_command,
   input  logic        reload_command,
   input  logic        target_locked,
   input  logic [13:0] distance_to_target,
   output logic        track_request,
   output logic        launch_missile,
   output logic [3:0]  remaining_missiles,
   output logic [1:0]  FCU_state
);

   localparam int PW = $clog2(FIRE_PULSE_CYCLES + 1);
   localparam int RW = $clog2(RETRACK_CYCLES + 1);

   localparam logic [13:0]   LP_MIN_RANGE  = 14'(MIN_RANGE);
   localparam logic [13:0]   LP_MAX_RANGE  = 14'(MAX_RANGE);
   localparam logic [3:0]    LP_MAGAZINE   = 4'(MAX_MISSILES);
   localparam logic [PW-1:0] LP_PULSE_LAST = PW'(FIRE_PULSE_CYCLES);
   localparam logic [RW-1:0] LP_RETRACK    = RW'(RETRACK_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE        = 2'b00,
      S_ARMED       = 2'b01,
      S_FIRING      = 2'b10,
      S_OUT_OF_AMMO = 2'b11
   } state_t;

   state_t        r_state,       w_state_nxt;
   logic          r_launch,      w_launch_nxt;
   logic          r_track,       w_track_nxt;
   logic [3:0]    r_remaining,   w_remaining_nxt;
   logic [PW-1:0] r_pulse_cnt,   w_pulse_cnt_nxt;
   logic [RW-1:0] r_retrack_cnt, w_retrack_cnt_nxt;

   logic          w_in_range;
   logic [RW-1:0] w_retrack_inc;

   // Both range bounds are inclusive.
   assign w_in_range = target_locked &&
                       (distance_to_target >= LP_MIN_RANGE) &&
                       (distance_to_target <= LP_MAX_RANGE);

   assign w_retrack_inc = r_retrack_cnt + 1'b1;

   always_comb begin
      w_state_nxt       = r_state;
      w_launch_nxt      = 1'b0;
      w_track_nxt       = 1'b0;
      w_remaining_nxt   = r_remaining;
      w_pulse_cnt_nxt   = r_pulse_cnt;
      w_retrack_cnt_nxt = r_retrack_cnt;

      case (r_state)
         S_IDLE: begin
            if (arm_command) begin
               // Arming asks the tracker for a fresh radar pass right away.
               w_state_nxt       = S_ARMED;
               w_track_nxt       = 1'b1;
               w_retrack_cnt_nxt = '0;
            end
         end

         S_ARMED: begin
            if (disarm_command) begin
               w_state_nxt = S_IDLE;
            end else if (fire_command && w_in_range && (r_remaining != 4'd0)) begin
               w_state_nxt     = S_FIRING;
               w_launch_nxt    = 1'b1;
               w_remaining_nxt = r_remaining - 4'd1;
               w_pulse_cnt_nxt = PW'(1);
            end else if (!target_locked) begin
               // Without a lock, ask for a new radar pass every RETRACK_CYCLES.
               if (w_retrack_inc == LP_RETRACK) begin
                  w_track_nxt       = 1'b1;
                  w_retrack_cnt_nxt = '0;
               end else begin
                  w_retrack_cnt_nxt = w_retrack_inc;
               end
            end else begin
               w_retrack_cnt_nxt = '0;
            end
         end

         S_FIRING: begin
            // This state ignores all commands and any loss of lock. The pulse
            // always runs to its full length.
            if (r_pulse_cnt == LP_PULSE_LAST) begin
               w_pulse_cnt_nxt   = '0;
               w_retrack_cnt_nxt = '0;
               w_state_nxt       = (r_remaining == 4'd0) ? S_OUT_OF_AMMO : S_ARMED;
            end else begin
               w_launch_nxt    = 1'b1;
               w_pulse_cnt_nxt = r_pulse_cnt + 1'b1;
            end
         end

         S_OUT_OF_AMMO: begin
            if (reload_command) begin
               w_remaining_nxt = LP_MAGAZINE;
               w_state_nxt     = S_IDLE;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_launch      <= 1'b0;
         r_track       <= 1'b0;
         r_remaining   <= LP_MAGAZINE;
         r_pulse_cnt   <= '0;
         r_retrack_cnt <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_launch      <= w_launch_nxt;
         r_track       <= w_track_nxt;
         r_remaining   <= w_remaining_nxt;
         r_pulse_cnt   <= w_pulse_cnt_nxt;
         r_retrack_cnt <= w_retrack_cnt_nxt;
      end
   end

   assign track_request      = r_track;
   assign launch_missile     = r_launch;
   assign remaining_missiles = r_remaining;
   assign FCU_state          = r_state;

endmodule
